loc_walk_datapath: RTL and testbench

Datapath for a 16×16 grid walker, driven by an external controller FSM.
- Holds the current location as an 8-bit `{x[3:0], y[3:0]}` pair in two 4-bit load-enabled registers.
- Computes a single-step neighbour location with a 4-bit adder.
- Flags when the step would leave the grid.
- Keeps a LIFO of visited locations so the walker can backtrack.

---
 rtl/loc_walk_datapath.sv | 108 ++++++++++
 tb/tb_loc_walk_datapath.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/loc_walk_datapath.sv
// Grid walker datapath: 4-bit x/y location registers, single-step adder, LIFO of visited cells.
// Optional per-clock trace print enabled by defining LOC_DP_TRACE_EN.
module loc_walk_datapath #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rgLd,
   input  logic [1:0] dir,
   input  logic       push,
   input  logic       pop,
   input  logic       adderEn,
   output logic       cntReach,
   output logic       empStck,
   output logic [7:0] nxtLoc,
   output logic [7:0] curLoc
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [3:0] xr;
   logic [3:0] yr;
   logic       sl;
   logic [3:0] sel;
   logic [3:0] addend;
   logic [3:0] sum;
   logic [7:0] stepped;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [AW-1:0] widx;
   logic [AW-1:0] ridx;
   logic [7:0]    top;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign curLoc = {xr, yr};

   assign sl  = dir[1] ^ dir[0];
   assign sel = sl ? xr : yr;

   always_comb begin
      addend = 4'h0;
      unique case (dir[0])
         1'b1: addend = 4'h1;
         1'b0: addend = 4'hF;
      endcase
   end

   assign sum      = adderEn ? (sel + addend) : 4'h0;
   assign cntReach = ((sel + {3'b000, dir[0]}) == 4'h0);
   assign stepped  = sl ? {sum, yr} : {xr, sum};

   assign empStck = (ptr == '0);
   assign full    = (ptr == PW'(DEPTH));
   assign widx    = ptr[AW-1:0];
   assign ridx    = AW'(ptr - PW'(1));
   assign top     = empStck ? 8'h00 : mem[ridx];

   // pop beats push; both ignored at the stack boundaries
   assign do_pop  = pop && !empStck;
   assign do_push = push && !pop && !full;

   always_comb begin
      nxtLoc = curLoc;
      if (rst)
         nxtLoc = 8'h00;
      else if (pop)
         nxtLoc = top;
      else if (adderEn)
         nxtLoc = stepped;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xr <= 4'h0;
         yr <= 4'h0;
      end else if (rgLd) begin
         xr <= nxtLoc[7:4];
         yr <= nxtLoc[3:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (do_pop)
         ptr <= ptr - PW'(1);
      else if (do_push)
         ptr <= ptr + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem[widx] <= curLoc;
   end

`ifdef LOC_DP_TRACE_EN
   always @(posedge clk) begin
      $display("loc_dp: curLoc=%b nxtLoc=%b dir=%b adderEn=%b sl=%b sel=%b",
               curLoc, nxtLoc, dir, adderEn, sl, sel);
   end
`else
`endif

endmodule

// File: tb/tb_loc_walk_datapath.sv
// Scoreboard bench for loc_walk_datapath: directed walk/stack sequences plus random traffic.
module tb_loc_walk_datapath;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rgLd = 1'b0;
   logic [1:0] dir = 2'b00;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       adderEn = 1'b0;
   logic       cntReach;
   logic       empStck;
   logic [7:0] nxtLoc;
   logic [7:0] curLoc;

   loc_walk_datapath #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rgLd(rgLd), .dir(dir),
      .push(push), .pop(pop), .adderEn(adderEn),
      .cntReach(cntReach), .empStck(empStck),
      .nxtLoc(nxtLoc), .curLoc(curLoc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] nxt;
      logic [7:0] cur;
      logic       cr;
      logic       emp;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   int mx = 0;
   int my = 0;
   int stk[$];
   bit known = 0;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // monitor: compares the outputs presented in the cycle each expectation was issued for
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("nxtLoc", nxtLoc, e.nxt);
         chk("curLoc", curLoc, e.cur);
         chk("cntReach", {7'b0, cntReach}, {7'b0, e.cr});
         chk("empStck", {7'b0, empStck}, {7'b0, e.emp});
      end
   end

   task automatic cyc(bit r, bit ld, bit [1:0] d, bit ps, bit pp, bit ae);
      exp_t e;
      bit plus, onx;
      int v, nx, ny;
      @(posedge clk);
      #1;
      rst = r; rgLd = ld; dir = d; push = ps; pop = pp; adderEn = ae;
      plus = (d == 2'b01) || (d == 2'b11);
      onx  = (d == 2'b01) || (d == 2'b10);
      v = onx ? mx : my;
      e.cr = plus ? (v == 15) : (v == 0);
      nx = mx;
      ny = my;
      if (r) begin
         nx = 0; ny = 0;
      end else if (pp) begin
         if (stk.size() > 0) begin
            nx = stk[$] / 16; ny = stk[$] % 16;
         end else begin
            nx = 0; ny = 0;
         end
      end else if (ae) begin
         v = (v + (plus ? 1 : -1) + 16) % 16;
         if (onx) nx = v; else ny = v;
      end
      e.nxt = 8'(nx * 16 + ny);
      e.cur = 8'(mx * 16 + my);
      e.emp = (stk.size() == 0);
      if (known) exp_q.push_back(e);
      if (r) begin
         mx = 0; my = 0; stk.delete(); known = 1;
      end else begin
         if (pp) begin
            if (stk.size() > 0) void'(stk.pop_back());
         end else if (ps && stk.size() < DEPTH) begin
            stk.push_back(mx * 16 + my);
         end
         if (ld) begin
            mx = nx; my = ny;
         end
      end
   endtask

   task automatic step(bit [1:0] d);
      cyc(0, 1, d, 0, 0, 1);
   endtask

   task automatic idle(bit [1:0] d);
      cyc(0, 0, d, 0, 0, 0);
   endtask

   initial begin
      cyc(1, 1, 2'b01, 1, 1, 1);
      cyc(1, 0, 2'b00, 0, 0, 0);
      idle(2'b00);
      step(2'b01); step(2'b11); step(2'b00); step(2'b10);
      idle(2'b00);
      step(2'b10);
      idle(2'b01); idle(2'b00); idle(2'b11); idle(2'b10);
      step(2'b01);
      idle(2'b00);
      step(2'b01); step(2'b01);
      step(2'b11); step(2'b11); step(2'b11);
      cyc(0, 0, 2'b00, 1, 0, 0);
      step(2'b11);
      cyc(0, 0, 2'b00, 1, 0, 0);
      step(2'b11);
      cyc(0, 1, 2'b00, 0, 1, 0);
      cyc(0, 1, 2'b00, 0, 1, 0);
      idle(2'b00);
      cyc(0, 1, 2'b00, 0, 1, 0);
      idle(2'b00);
      cyc(0, 0, 2'b00, 1, 0, 0);
      cyc(0, 0, 2'b00, 1, 1, 0);
      idle(2'b00);
      for (int i = 0; i < DEPTH + 1; i++) begin
         step(2'b01);
         cyc(0, 0, 2'b00, 1, 0, 0);
      end
      for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 2'b00, 0, 1, 0);
      cyc(0, 1, 2'b00, 1, 0, 1);
      cyc(1, 1, 2'b11, 1, 0, 1);
      idle(2'b00);
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 60) == 0),
             1'($urandom), 2'($urandom),
             ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 3) == 0),
             1'($urandom));
      end
      idle(2'b00);
      @(posedge clk);
      @(negedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
